// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller: FSM states and the
// reset / clamp constants for the period, target and step registers.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam int RST_PERIOD = 1;
  localparam int RST_TARGET = 0;
  localparam int RST_STEP   = 1;
  localparam int MIN_PERIOD = 1;
  localparam int MIN_STEP   = 1;

endpackage

// File: rtl/pwm_counter.sv
// Period counter and duty compare. The compare is done on the next count
// and next duty so the registered pwm_out lines up with the live count:
// during the cycle where cnt == k, pwm_out is (k < duty).
module pwm_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             run_nxt,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty_nxt,
  output logic             pwm_out,
  output logic             period_end
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Last cycle of the period; never flagged while the controller is idle.
  always_comb begin
    period_end = run && (cnt == period - CNT_W'(1));
  end

  // Next count: back to 0 on wrap, on start-up and whenever not running.
  always_comb begin
    cnt_nxt = '0;
    if (run && run_nxt && !period_end) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Count register and registered PWM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      pwm_out <= run_nxt && (cnt_nxt < duty_nxt);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM generator with a ramped duty cycle. Configs are accepted into shadow
// registers and copied to the active set on period boundaries; the FSM walks
// the duty toward the target (RAMP), holds it (HOLD) or ramps it down to
// zero before going idle (STOP).
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [CNT_W-1:0] cfg_step,
  output logic             pwm_out,
  output logic             period_end,
  output logic [CNT_W-1:0] cur_duty,
  output logic             at_target,
  output logic             busy
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] per_a, tgt_a, step_a;
  logic [CNT_W-1:0] per_s, tgt_s, step_s;
  logic [CNT_W-1:0] per_c, tgt_c, step_c;
  logic [CNT_W-1:0] duty, duty_n;
  logic [DIV_W-1:0] div, div_n;
  logic             accept;
  logic             step_due;
  logic             run;
  logic             run_nxt;

  // One ramp step from d toward t, saturating at t; done one bit wider so
  // d + s and t + s cannot wrap.
  function automatic logic [CNT_W-1:0] step_toward(input logic [CNT_W-1:0] d,
                                                   input logic [CNT_W-1:0] t,
                                                   input logic [CNT_W-1:0] s);
    logic [CNT_W:0] dw, tw, sw, res;
    dw = {1'b0, d};
    tw = {1'b0, t};
    sw = {1'b0, s};
    if (dw < tw) begin
      res = (dw + sw >= tw) ? tw : dw + sw;
    end else if (dw > tw) begin
      res = (dw >= tw + sw) ? dw - sw : tw;
    end else begin
      res = tw;
    end
    return res[CNT_W-1:0];
  endfunction

  // Clamp an offered config into range; the target is limited by the
  // already-clamped period.
  always_comb begin
    per_c  = (cfg_period == '0) ? CNT_W'(MIN_PERIOD) : cfg_period;
    step_c = (cfg_step == '0) ? CNT_W'(MIN_STEP) : cfg_step;
    tgt_c  = (cfg_target > per_c) ? per_c : cfg_target;
  end

  // Status outputs decoded from the current state.
  always_comb begin
    cfg_ready = (state == IDLE) || (state == HOLD);
    at_target = (state == HOLD);
    busy      = (state == RAMP) || (state == STOP);
    cur_duty  = duty;
  end

  assign accept   = cfg_valid && cfg_ready;
  assign run      = (state != IDLE);
  assign run_nxt  = (state_n != IDLE);
  assign step_due = period_end && (div == DIV_LAST);

  // Next state, next duty and ramp divider. A step lands on every
  // STEP_DIV-th period_end so the new duty starts with the next period.
  always_comb begin
    state_n = state;
    duty_n  = duty;
    div_n   = div;
    case (state)
      IDLE: begin
        duty_n = '0;
        div_n  = '0;
        if (enable) state_n = RAMP;
      end
      RAMP: begin
        if (!enable) begin
          state_n = STOP;
          div_n   = '0;
        end else if (duty == tgt_a) begin
          state_n = HOLD;
          div_n   = '0;
        end else if (period_end) begin
          div_n = step_due ? '0 : div + DIV_W'(1);
          if (step_due) duty_n = step_toward(duty, tgt_a, step_a);
        end
      end
      HOLD: begin
        if (!enable) begin
          state_n = STOP;
        end else if (period_end && (tgt_s != duty)) begin
          // The target being applied right now counts as the first ramp tick.
          state_n = RAMP;
          div_n   = step_due ? '0 : div + DIV_W'(1);
          if (step_due) duty_n = step_toward(duty, tgt_s, step_s);
        end
      end
      STOP: begin
        if (enable) begin
          state_n = RAMP;
          div_n   = '0;
        end else if (period_end) begin
          if (duty == '0) begin
            state_n = IDLE;
            div_n   = '0;
          end else begin
            div_n = step_due ? '0 : div + DIV_W'(1);
            if (step_due) duty_n = step_toward(duty, '0, step_a);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, duty and divider registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      duty  <= '0;
      div   <= '0;
    end else begin
      state <= state_n;
      duty  <= duty_n;
      div   <= div_n;
    end
  end

  // Shadow registers take accepted configs; the active set follows at
  // period_end, or at once while idle since nothing is running then.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_a  <= CNT_W'(RST_PERIOD);
      tgt_a  <= CNT_W'(RST_TARGET);
      step_a <= CNT_W'(RST_STEP);
      per_s  <= CNT_W'(RST_PERIOD);
      tgt_s  <= CNT_W'(RST_TARGET);
      step_s <= CNT_W'(RST_STEP);
    end else begin
      if (accept) begin
        per_s  <= per_c;
        tgt_s  <= tgt_c;
        step_s <= step_c;
      end
      if ((state == IDLE) && accept) begin
        per_a  <= per_c;
        tgt_a  <= tgt_c;
        step_a <= step_c;
      end else if (period_end) begin
        per_a  <= per_s;
        tgt_a  <= tgt_s;
        step_a <= step_s;
      end
    end
  end

  pwm_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .run_nxt   (run_nxt),
    .period    (per_a),
    .duty_nxt  (duty_n),
    .pwm_out   (pwm_out),
    .period_end(period_end)
  );

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl: directed scenarios plus randomized ramps
// checked against a period-level model of the duty sequence.
module tb_pwm_ramp_ctrl;

  localparam int CNT_W    = 8;
  localparam int STEP_DIV = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_target;
  logic [CNT_W-1:0] cfg_step;
  logic             pwm_out;
  logic             period_end;
  logic [CNT_W-1:0] cur_duty;
  logic             at_target;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .CNT_W   (CNT_W),
    .STEP_DIV(STEP_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_period(cfg_period),
    .cfg_target(cfg_target),
    .cfg_step  (cfg_step),
    .pwm_out   (pwm_out),
    .period_end(period_end),
    .cur_duty  (cur_duty),
    .at_target (at_target),
    .busy      (busy)
  );

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  // Offer one config for a single cycle; the DUT must be ready for it.
  task automatic configure(input int p, input int t, input int s);
    tests_run++;
    if (cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL cfg_ready_on_offer: got %b expected 1", cfg_ready);
    end
    cfg_valid  = 1'b1;
    cfg_period = p[CNT_W-1:0];
    cfg_target = t[CNT_W-1:0];
    cfg_step   = s[CNT_W-1:0];
    cyc();
    cfg_valid = 1'b0;
  endtask

  // Observe from the current cycle up to and including the next period_end.
  task automatic finish_period(output int highs, output int len, output int duty,
                               output bit changed, output bit tgt_end,
                               output bit saw_idle);
    highs    = 0;
    len      = 0;
    duty     = int'(cur_duty);
    changed  = 1'b0;
    tgt_end  = 1'b0;
    saw_idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      len++;
      if (pwm_out === 1'b1) highs++;
      if (int'(cur_duty) != duty) changed = 1'b1;
      if (busy !== 1'b1 && at_target !== 1'b1) saw_idle = 1'b1;
      if (period_end === 1'b1) begin
        tgt_end = at_target;
        return;
      end
      cyc();
    end
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL period_timeout: period_end not seen in 400 cycles, duty %0d", duty);
  endtask

  task automatic measure_next_period(output int highs, output int len, output int duty,
                                     output bit changed, output bit tgt_end,
                                     output bit saw_idle);
    cyc();
    finish_period(highs, len, duty, changed, tgt_end, saw_idle);
  endtask

  // Reference rule: one ramp step from d toward t, never past t.
  function automatic int toward(input int d, input int t, input int s);
    if (d < t) return (d + s > t) ? t : d + s;
    if (d > t) return (d - s < t) ? t : d - s;
    return d;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic test_reset();
    int h, l, d;
    bit ch, te, si;
    rst        = 1'b1;
    enable     = 1'b1;
    cfg_valid  = 1'b1;
    cfg_period = 8'd77;
    cfg_target = 8'd33;
    cfg_step   = 8'd9;
    cyc();
    cfg_valid = 1'b0;
    enable    = 1'b0;
    tests_run++;
    if ({pwm_out, period_end, at_target, busy, cfg_ready} !== 5'b00001 || cur_duty !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got pwm=%b pe=%b at=%b busy=%b rdy=%b duty=%0d expected 0,0,0,0,1,0",
               pwm_out, period_end, at_target, busy, cfg_ready, cur_duty);
    end
    rst    = 1'b0;
    enable = 1'b1;
    // Reset registers are period 1, target 0: one-cycle periods, always low.
    for (int k = 0; k < 3; k++) begin
      measure_next_period(h, l, d, ch, te, si);
      tests_run++;
      if (l != 1 || h != 0 || d != 0) begin
        tests_failed++;
        $display("[TB] FAIL reset_regs[%0d]: got len=%0d highs=%0d duty=%0d expected 1,0,0", k, l, h, d);
      end
    end
    tests_run++;
    if (te !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: got at_target=%b expected 1", te);
    end
    enable = 1'b0;
    cyc();
    cyc();
    tests_run++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_back_idle: got busy=%b rdy=%b expected 0,1", busy, cfg_ready);
    end
  endtask

  task automatic test_basic_ramp();
    int exp_d[6] = '{0, 2, 4, 6, 6, 6};
    int h, l, d;
    bit ch, te, si;
    apply_reset();
    configure(10, 6, 2);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      measure_next_period(h, l, d, ch, te, si);
      tests_run++;
      if (d != exp_d[k] || h != exp_d[k] || l != 10 || ch) begin
        tests_failed++;
        $display("[TB] FAIL basic_period[%0d]: got duty=%0d highs=%0d len=%0d expected %0d,%0d,10",
                 k, d, h, l, exp_d[k], exp_d[k]);
      end
    end
    tests_run++;
    if (te !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_at_target: got %b expected 1", te);
    end
  endtask

  // Starts in HOLD at duty 6, sitting on a period_end cycle.
  task automatic test_retarget();
    int exp_d[3] = '{4, 3, 3};
    int h, l, d;
    bit ch, te, si;
    cyc();
    cyc();
    cyc();
    configure(10, 3, 2);
    finish_period(h, l, d, ch, te, si);
    tests_run++;
    if (d != 6 || ch || te !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL retarget_no_early_change: got duty=%0d changed=%b at=%b expected 6,0,1", d, ch, te);
    end
    for (int k = 0; k < 3; k++) begin
      measure_next_period(h, l, d, ch, te, si);
      tests_run++;
      if (d != exp_d[k] || h != exp_d[k]) begin
        tests_failed++;
        $display("[TB] FAIL retarget_period[%0d]: got duty=%0d highs=%0d expected %0d", k, d, h, exp_d[k]);
      end
    end
    tests_run++;
    if (te !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL retarget_hold: got at_target=%b expected 1", te);
    end
  endtask

  // Config accepted on the very period_end cycle waits a whole period.
  task automatic test_boundary_accept();
    int exp_d[3] = '{5, 6, 6};
    int h, l, d;
    bit ch, te, si;
    configure(10, 6, 2);
    finish_period(h, l, d, ch, te, si);
    tests_run++;
    if (d != 3 || h != 3 || l != 10 || ch || te !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL boundary_deferred: got duty=%0d highs=%0d len=%0d at=%b expected 3,3,10,1", d, h, l, te);
    end
    for (int k = 0; k < 3; k++) begin
      measure_next_period(h, l, d, ch, te, si);
      tests_run++;
      if (d != exp_d[k] || h != exp_d[k]) begin
        tests_failed++;
        $display("[TB] FAIL boundary_period[%0d]: got duty=%0d highs=%0d expected %0d", k, d, h, exp_d[k]);
      end
    end
  endtask

  // Starts in HOLD at duty 6 on a period_end cycle.
  task automatic test_disable_reenable();
    int exp_d[3] = '{4, 6, 6};
    int h, l, d;
    bit ch, te, si;
    bit any_idle;
    enable = 1'b0;
    measure_next_period(h, l, d, ch, te, si);
    tests_run++;
    if (d != 6 || si || te !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stop_first: got duty=%0d idle=%b at=%b expected 6,0,0", d, si, te);
    end
    measure_next_period(h, l, d, ch, te, si);
    tests_run++;
    if (d != 4 || h != 4 || si) begin
      tests_failed++;
      $display("[TB] FAIL stop_down: got duty=%0d highs=%0d idle=%b expected 4,4,0", d, h, si);
    end
    cyc();
    enable = 1'b1;
    finish_period(h, l, d, ch, te, si);
    any_idle = si;
    tests_run++;
    if (d != 2 || ch) begin
      tests_failed++;
      $display("[TB] FAIL stop_resume_duty: got duty=%0d changed=%b expected 2,0", d, ch);
    end
    for (int k = 0; k < 3; k++) begin
      measure_next_period(h, l, d, ch, te, si);
      any_idle |= si;
      tests_run++;
      if (d != exp_d[k] || h != exp_d[k]) begin
        tests_failed++;
        $display("[TB] FAIL reenable_period[%0d]: got duty=%0d highs=%0d expected %0d", k, d, h, exp_d[k]);
      end
    end
    tests_run++;
    if (any_idle || te !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reenable_path: got idle_seen=%b at=%b expected 0,1", any_idle, te);
    end
  endtask

  task automatic test_clamp();
    int h, l, d;
    bit ch, te, si;
    int highs;
    apply_reset();
    configure(0, 5, 0);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      measure_next_period(h, l, d, ch, te, si);
      tests_run++;
      if (l != 1 || d != ((k == 0) ? 0 : 1)) begin
        tests_failed++;
        $display("[TB] FAIL clamp_period[%0d]: got len=%0d duty=%0d expected 1,%0d", k, l, d, (k == 0) ? 0 : 1);
      end
    end
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (pwm_out === 1'b1) highs++;
    end
    tests_run++;
    if (highs != 8 || at_target !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL clamp_full_on: got highs=%0d/8 at=%b expected 8,1", highs, at_target);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int h, l, d;
    bit ch, te, si;
    int highs;
    apply_reset();
    configure(20, 20, 1);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) measure_next_period(h, l, d, ch, te, si);
    cyc();
    rst    = 1'b1;
    enable = 1'b0;
    cyc();
    rst = 1'b0;
    tests_run++;
    if ({pwm_out, period_end, at_target, busy, cfg_ready} !== 5'b00001 || cur_duty !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midramp_reset: got pwm=%b pe=%b at=%b busy=%b rdy=%b duty=%0d expected 0,0,0,0,1,0",
               pwm_out, period_end, at_target, busy, cfg_ready, cur_duty);
    end
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (pwm_out !== 1'b0 || period_end !== 1'b0) highs++;
    end
    tests_run++;
    if (highs != 0) begin
      tests_failed++;
      $display("[TB] FAIL midramp_residual: got %0d active cycles expected 0", highs);
    end
  endtask

  task automatic test_random_ramps();
    int h, l, d;
    bit ch, te, si;
    int p, t, s, pc, tc, sc, exp_d, div, held;
    for (int iter = 0; iter < 6; iter++) begin
      p  = $urandom_range(0, 30);
      t  = $urandom_range(0, 40);
      s  = $urandom_range(0, 12);
      pc = (p == 0) ? 1 : p;
      sc = (s == 0) ? 1 : s;
      tc = min2(t, pc);
      apply_reset();
      configure(p, t, s);
      enable = 1'b1;
      exp_d  = 0;
      div    = 0;
      held   = 0;
      for (int k = 0; k < 100 && held < 2; k++) begin
        measure_next_period(h, l, d, ch, te, si);
        tests_run++;
        if (d != exp_d || h != min2(exp_d, pc) || l != pc) begin
          tests_failed++;
          $display("[TB] FAIL rand_up[%0d.%0d] p=%0d t=%0d s=%0d: got duty=%0d highs=%0d len=%0d expected %0d,%0d,%0d",
                   iter, k, p, t, s, d, h, l, exp_d, min2(exp_d, pc), pc);
        end
        if (exp_d == tc) begin
          held++;
        end else begin
          div++;
          if (div == STEP_DIV) begin
            exp_d = toward(exp_d, tc, sc);
            div   = 0;
          end
        end
      end
      tests_run++;
      if (te !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL rand_hold[%0d]: got at_target=%b expected 1", iter, te);
      end
      enable = 1'b0;
      div    = 0;
      for (int k = 0; k < 100; k++) begin
        measure_next_period(h, l, d, ch, te, si);
        tests_run++;
        if (d != exp_d || h != min2(exp_d, pc)) begin
          tests_failed++;
          $display("[TB] FAIL rand_down[%0d.%0d]: got duty=%0d highs=%0d expected %0d,%0d",
                   iter, k, d, h, exp_d, min2(exp_d, pc));
        end
        if (exp_d == 0) break;
        div++;
        if (div == STEP_DIV) begin
          exp_d = toward(exp_d, 0, sc);
          div   = 0;
        end
      end
      cyc();
      tests_run++;
      if (busy !== 1'b0 || cfg_ready !== 1'b1 || cur_duty !== '0) begin
        tests_failed++;
        $display("[TB] FAIL rand_idle[%0d]: got busy=%b rdy=%b duty=%0d expected 0,1,0",
                 iter, busy, cfg_ready, cur_duty);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_target = '0;
    cfg_step   = '0;
    test_reset();
    test_basic_ramp();
    test_retarget();
    test_boundary_accept();
    test_disable_reenable();
    test_clamp();
    test_reset_mid_ramp();
    test_random_ramps();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failed so far", tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
